// File: rtl/idct_8pt_serial.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : idct_8pt_serial                                               |
// | Description : 8-point inverse DCT. One frame of 8 coefficients is loaded     |
// |               serially, reconstructed with a single time-multiplexed MAC    |
// |               against a combinational cosine ROM, then drained serially as  |
// |               rounded, saturated samples.                                   |
// |               Optional sticky clamp indicator: define IDCT_SAT_FLAG_EN.     |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module idct_8pt_serial #(
    parameter int COEF_W = 19,
    parameter int ROM_W  = 16,
    parameter int OUT_W  = 8,
    parameter int SHIFT  = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [COEF_W-1:0] in_coef,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_sample,
`ifdef IDCT_SAT_FLAG_EN
    output logic              sat_flag,
`endif
    output logic              busy
);

    localparam int c_ACC_W  = 38;
    localparam int c_PROD_W = COEF_W + ROM_W;
    localparam logic signed [c_ACC_W-1:0] c_RND = c_ACC_W'(1) <<< (SHIFT - 1);
    localparam logic signed [c_ACC_W-1:0] c_MAX = (c_ACC_W'(1) <<< (OUT_W - 1)) - c_ACC_W'(1);
    localparam logic signed [c_ACC_W-1:0] c_MIN = -(c_ACC_W'(1) <<< (OUT_W - 1));

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_CALC  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [2:0]                r_kcnt;
    logic [5:0]                r_icnt;
    logic [2:0]                r_ocnt;
    logic signed [COEF_W-1:0]  r_buf  [0:7];
    logic signed [OUT_W-1:0]   r_obuf [0:7];
    logic signed [c_ACC_W-1:0] r_acc;
    logic                      r_in_ready;
    logic                      r_out_valid;
    logic [OUT_W-1:0]          r_out_sample;

    logic                      w_in_fire;
    logic                      w_out_fire;
    logic [2:0]                w_n;
    logic [2:0]                w_k;
    logic signed [ROM_W-1:0]   w_rom;
    logic signed [c_PROD_W-1:0] w_prod;
    logic signed [c_ACC_W-1:0] w_acc_nxt;
    logic signed [c_ACC_W-1:0] w_rnd;
    logic signed [c_ACC_W-1:0] w_shr;
    logic signed [OUT_W-1:0]   w_res;

    // Cosine ROM in Q1.14: C[n][k] = 16384*a_k*cos((2n+1)k*pi/16), folded onto
    // one quarter-wave table of 8192*cos(m*pi/16). The 5-bit multiply wraps mod 32,
    // which is exactly the period of the cosine argument in units of pi/16.
    function automatic logic signed [ROM_W-1:0] rom_coef(input logic [5:0] addr);
        logic [4:0]              m;
        logic [4:0]              f;
        logic                    neg;
        logic signed [ROM_W-1:0] mag;
        m   = {1'b0, addr[5:3], 1'b1} * {2'b00, addr[2:0]};
        f   = (m > 5'd16) ? (5'd0 - m) : m;
        neg = (f > 5'd8);
        if (neg) begin
            f = 5'd16 - f;
        end
        case (f)
            5'd0:    mag = ROM_W'(8192);
            5'd1:    mag = ROM_W'(8035);
            5'd2:    mag = ROM_W'(7568);
            5'd3:    mag = ROM_W'(6811);
            5'd4:    mag = ROM_W'(5793);
            5'd5:    mag = ROM_W'(4551);
            5'd6:    mag = ROM_W'(3135);
            5'd7:    mag = ROM_W'(1598);
            default: mag = '0;
        endcase
        if (addr[2:0] == 3'd0) begin
            rom_coef = ROM_W'(5793);
        end else begin
            rom_coef = neg ? -mag : mag;
        end
    endfunction

    assign w_in_fire  = en && in_valid && r_in_ready && (r_state == S_LOAD);
    assign w_out_fire = en && r_out_valid && out_ready && (r_state == S_DRAIN);
    assign w_n        = r_icnt[5:3];
    assign w_k        = r_icnt[2:0];

    // MAC step: accumulator restarts at k=0, then round-half-up, shift and clamp.
    always_comb begin
        w_rom     = rom_coef({w_n, w_k});
        w_prod    = r_buf[w_k] * w_rom;
        w_acc_nxt = ((w_k == 3'd0) ? '0 : r_acc)
                    + {{(c_ACC_W - c_PROD_W){w_prod[c_PROD_W-1]}}, w_prod};
        w_rnd     = w_acc_nxt + c_RND;
        w_shr     = w_rnd >>> SHIFT;
        if (w_shr > c_MAX) begin
            w_res = {1'b0, {(OUT_W - 1){1'b1}}};
        end else if (w_shr < c_MIN) begin
            w_res = {1'b1, {(OUT_W - 1){1'b0}}};
        end else begin
            w_res = w_shr[OUT_W-1:0];
        end
    end

    // Next-state decision; every transition already requires en.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_LOAD:  if (w_in_fire && (r_kcnt == 3'd7)) w_state_nxt = S_CALC;
            S_CALC:  if (en && (r_icnt == 6'd63))       w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_out_fire && (r_ocnt == 3'd7)) w_state_nxt = S_LOAD;
            default: w_state_nxt = S_LOAD;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath: load buffer, MAC/accumulate into obuf, serial drain; frozen when en=0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_kcnt       <= '0;
            r_icnt       <= '0;
            r_ocnt       <= '0;
            r_acc        <= '0;
            r_in_ready   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_sample <= '0;
            for (int i = 0; i < 8; i++) begin
                r_buf[i]  <= '0;
                r_obuf[i] <= '0;
            end
        end else if (en) begin
            case (r_state)
                S_LOAD: begin
                    r_in_ready <= 1'b1;
                    if (w_in_fire) begin
                        r_buf[r_kcnt] <= $signed(in_coef);
                        r_kcnt        <= r_kcnt + 3'd1;
                        if (r_kcnt == 3'd7) begin
                            r_in_ready <= 1'b0;
                        end
                    end
                end
                S_CALC: begin
                    r_acc  <= w_acc_nxt;
                    r_icnt <= r_icnt + 6'd1;
                    if (w_k == 3'd7) begin
                        r_obuf[w_n] <= w_res;
                    end
                end
                S_DRAIN: begin
                    if (!r_out_valid) begin
                        r_out_valid  <= 1'b1;
                        r_out_sample <= r_obuf[r_ocnt];
                    end else if (out_ready) begin
                        r_ocnt <= r_ocnt + 3'd1;
                        if (r_ocnt == 3'd7) begin
                            r_out_valid <= 1'b0;
                            r_in_ready  <= 1'b1;
                        end else begin
                            r_out_sample <= r_obuf[r_ocnt + 3'd1];
                        end
                    end
                end
                default: begin
                    r_in_ready <= 1'b0;
                end
            endcase
        end
    end

`ifdef IDCT_SAT_FLAG_EN
    logic w_clamp;
    logic r_sat_flag;

    assign w_clamp = (w_shr > c_MAX) || (w_shr < c_MIN);

    // Sticky clamp indicator, cleared when a new frame starts loading.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sat_flag <= 1'b0;
        end else if (en) begin
            if ((r_state == S_CALC) && (w_k == 3'd7) && w_clamp) begin
                r_sat_flag <= 1'b1;
            end else if (w_in_fire && (r_kcnt == 3'd0)) begin
                r_sat_flag <= 1'b0;
            end
        end
    end

    assign sat_flag = r_sat_flag;
`endif

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_sample = r_out_sample;
    assign busy       = (r_state != S_LOAD);

endmodule
`default_nettype wire

// File: tb/tb_idct_8pt_serial.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_idct_8pt_serial                                            |
// | Description : Directed bench for idct_8pt_serial with hand-computed frames. |
// |               Define IDCT_SAT_FLAG_EN to also exercise sat_flag.           |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_idct_8pt_serial;

    localparam int COEF_W = 19;
    localparam int OUT_W  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              in_valid;
    logic              in_ready;
    logic [COEF_W-1:0] in_coef;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_sample;
    logic              busy;
`ifdef IDCT_SAT_FLAG_EN
    logic              sat_flag;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int coefs [8];
    int exps  [8];

    always #5 clk = ~clk;

    idct_8pt_serial dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_coef    (in_coef),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sample (out_sample),
`ifdef IDCT_SAT_FLAG_EN
        .sat_flag   (sat_flag),
`endif
        .busy       (busy)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Feed coefs[0..7]; optionally drop en for 10 cycles before coefficient stall_k.
    task automatic load_frame(input int stall_k);
        for (int k = 0; k < 8; k++) begin
            bit took;
            int guard;
            in_valid = 1'b1;
            in_coef  = COEF_W'(coefs[k]);
            if (k == stall_k) begin
                en = 1'b0;
                repeat (10) tick();
                chk("load_freeze_ready", int'(in_ready), 1);
                chk("load_freeze_busy", int'(busy), 0);
                en = 1'b1;
            end
            took  = 1'b0;
            guard = 0;
            while (!took && guard < 20) begin
                took = in_ready && en;
                tick();
                guard++;
            end
            if (!took) chk($sformatf("load_timeout_k%0d", k), 0, 1);
        end
        in_valid = 1'b0;
        in_coef  = '0;
    endtask

    // Count edges from the 8th accept to the first out_valid.
    task automatic wait_out(input bit stall_calc, input int exp_lat);
        int cyc;
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            en = !(stall_calc && cyc >= 20 && cyc < 30);
            if (cyc == 10) begin
                chk("calc_in_ready", int'(in_ready), 0);
                chk("calc_busy", int'(busy), 1);
            end
            tick();
            cyc++;
        end
        en = 1'b1;
        chk("latency", cyc, exp_lat);
    endtask

    // Drain 8 samples against exps; optional out_ready toggling and en freeze.
    task automatic drain(input bit toggle, input int stall_s);
        int         s;
        int         guard;
        bit         stalled;
        logic [7:0] prev;
        s       = 0;
        guard   = 0;
        stalled = 1'b0;
        while (s < 8 && guard < 100) begin
            out_ready = toggle ? (guard % 2 == 0) : 1'b1;
            if (s == stall_s && !stalled) begin
                stalled = 1'b1;
                prev    = out_sample;
                en      = 1'b0;
                repeat (10) tick();
                chk("drain_freeze_valid", int'(out_valid), 1);
                chk("drain_freeze_hold", int'(out_sample), int'(prev));
                en = 1'b1;
            end
            chk("drain_in_ready", int'(in_ready), 0);
            if (out_valid && out_ready) begin
                chk($sformatf("sample%0d", s), int'($signed(out_sample)), exps[s]);
                s++;
                tick();
            end else begin
                prev = out_sample;
                tick();
                if (out_valid) chk("hold_stable", int'(out_sample), int'(prev));
            end
            guard++;
        end
        if (s < 8) chk("drain_timeout", s, 8);
        out_ready = 1'b0;
        chk("post_out_valid", int'(out_valid), 0);
        chk("post_in_ready", int'(in_ready), 1);
        chk("post_busy", int'(busy), 0);
    endtask

    task automatic run_frame(input int stall_k, input bit stall_calc, input bit toggle,
                             input int stall_s);
        load_frame(stall_k);
        wait_out(stall_calc, stall_calc ? 75 : 65);
        drain(toggle, stall_s);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        en        = 1'b1;
        in_valid  = 1'b0;
        in_coef   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_out_sample", int'(out_sample), 0);
`ifdef IDCT_SAT_FLAG_EN
        chk("rst_sat_flag", int'(sat_flag), 0);
`endif
        rst = 1'b0;
        chk("rel_in_ready_first", int'(in_ready), 0);
        tick();
        chk("rel_in_ready_then", int'(in_ready), 1);

        // DC frame
        coefs = '{80, 0, 0, 0, 0, 0, 0, 0};
        exps  = '{28, 28, 28, 28, 28, 28, 28, 28};
        run_frame(-1, 1'b0, 1'b0, -1);
`ifdef IDCT_SAT_FLAG_EN
        chk("sat_flag_dc", int'(sat_flag), 0);
`endif

        // X1 only, out_ready toggling, back-to-back
        coefs = '{0, 64, 0, 0, 0, 0, 0, 0};
        exps  = '{31, 27, 18, 6, -6, -18, -27, -31};
        run_frame(-1, 1'b0, 1'b1, -1);

        // X2 only
        coefs = '{0, 0, 64, 0, 0, 0, 0, 0};
        exps  = '{30, 12, -12, -30, -30, -12, 12, 30};
        run_frame(-1, 1'b0, 1'b1, -1);

        // X7 only
        coefs = '{0, 0, 0, 0, 0, 0, 0, 64};
        exps  = '{6, -18, 27, -31, 31, -27, 18, -6};
        run_frame(-1, 1'b0, 1'b0, -1);

        // X0 + X1 mix
        coefs = '{80, 64, 0, 0, 0, 0, 0, 0};
        exps  = '{60, 55, 46, 35, 22, 11, 2, -3};
        run_frame(-1, 1'b0, 1'b0, -1);

        // Positive clamp
        coefs = '{2000, 0, 0, 0, 0, 0, 0, 0};
        exps  = '{127, 127, 127, 127, 127, 127, 127, 127};
        run_frame(-1, 1'b0, 1'b0, -1);
`ifdef IDCT_SAT_FLAG_EN
        chk("sat_flag_pos", int'(sat_flag), 1);
`endif

        // Negative clamp
        coefs = '{-2000, 0, 0, 0, 0, 0, 0, 0};
        exps  = '{-128, -128, -128, -128, -128, -128, -128, -128};
        run_frame(-1, 1'b0, 1'b0, -1);

        // DC frame with en freezes in LOAD, CALC and DRAIN
        coefs = '{80, 0, 0, 0, 0, 0, 0, 0};
        exps  = '{28, 28, 28, 28, 28, 28, 28, 28};
        load_frame(4);
`ifdef IDCT_SAT_FLAG_EN
        chk("sat_flag_cleared", int'(sat_flag), 0);
`endif
        wait_out(1'b1, 75);
        drain(1'b0, 3);

        // Reset mid-CALC discards the partial frame
        coefs = '{0, 64, 0, 0, 0, 0, 0, 0};
        load_frame(-1);
        repeat (30) tick();
        rst = 1'b1;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_in_ready", int'(in_ready), 0);
        chk("midrst_out_valid", int'(out_valid), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_rel_ready", int'(in_ready), 0);
        tick();
        chk("midrst_ready_back", int'(in_ready), 1);
        coefs = '{80, 0, 0, 0, 0, 0, 0, 0};
        exps  = '{28, 28, 28, 28, 28, 28, 28, 28};
        run_frame(-1, 1'b0, 1'b1, -1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
